// File: rtl/program_sequencer.sv
// Program counter with a LIFO return stack for CALL/RET. PC, stack level and the
// sticky error flag are registers; stack status outputs are decoded from the level.
module program_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         STALL,
    input  logic                         I_PC,
    input  logic                         L_PC,
    input  logic                         S11,
    input  logic                         S10,
    input  logic                         CALL,
    input  logic                         RET,
    input  logic [ADDR_W-1:0]            OR2_in,
    input  logic [ADDR_W-1:0]            R0_in,
    input  logic [ADDR_W-1:0]            DM_in,
    output logic [ADDR_W-1:0]            PC_out,
    output logic                         STK_EMPTY,
    output logic                         STK_FULL,
    output logic [$clog2(STACK_DEPTH):0] STK_LEVEL,
    output logic                         STK_ERR
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int LW = IW + 1;

    logic [ADDR_W-1:0] pc;
    logic [LW-1:0]     level;
    logic              err;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     push_idx;
    logic              empty;
    logic              full;
    logic              do_push;

    assign pc_inc   = pc + ADDR_W'(1);
    assign empty    = (level == '0);
    assign full     = (level == LW'(STACK_DEPTH));
    assign push_idx = level[IW-1:0];
    assign top_idx  = level[IW-1:0] - IW'(1);

    // OR2_in already spans the full PC width, so its sign extension is the value itself.
    always_comb begin
        target = pc + OR2_in;
        case ({S11, S10})
            2'b11:   target = R0_in;
            2'b10:   target = DM_in;
            2'b01:   target = OR2_in;
            default: target = pc + OR2_in;
        endcase
    end

    assign do_push = !STALL && !RET && CALL && !full;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc    <= RESET_VEC;
            level <= '0;
            err   <= 1'b0;
        end else if (!STALL) begin
            if (RET) begin
                if (!empty) begin
                    pc    <= stack[top_idx];
                    level <= level - LW'(1);
                end else begin
                    err <= 1'b1;
                end
            end else if (CALL) begin
                pc <= target;
                if (!full) begin
                    level <= level + LW'(1);
                end else begin
                    err <= 1'b1;
                end
            end else if (L_PC) begin
                pc <= target;
            end else if (I_PC) begin
                pc <= pc_inc;
            end
        end
    end

    // Entries are unreadable while empty, so the array itself needs no reset.
    always_ff @(posedge CLK) begin
        if (!RST && do_push) begin
            stack[push_idx] <= pc_inc;
        end
    end

    assign PC_out    = pc;
    assign STK_LEVEL = level;
    assign STK_EMPTY = empty;
    assign STK_FULL  = full;
    assign STK_ERR   = err;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed vector table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_program_sequencer;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             STALL = 1'b0, I_PC = 1'b0, L_PC = 1'b0, S11 = 1'b0, S10 = 1'b0;
    logic             CALL = 1'b0, RET = 1'b0;
    logic [ADDR_W-1:0] OR2_in = '0, R0_in = '0, DM_in = '0;
    logic [ADDR_W-1:0] PC_out;
    logic             STK_EMPTY, STK_FULL, STK_ERR;
    logic [2:0]       STK_LEVEL;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_q[$];

    program_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_VEC(8'h00)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .I_PC(I_PC), .L_PC(L_PC),
        .S11(S11), .S10(S10), .CALL(CALL), .RET(RET),
        .OR2_in(OR2_in), .R0_in(R0_in), .DM_in(DM_in),
        .PC_out(PC_out), .STK_EMPTY(STK_EMPTY), .STK_FULL(STK_FULL),
        .STK_LEVEL(STK_LEVEL), .STK_ERR(STK_ERR)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct {
        logic       stall, ret, call, lpc, ipc;
        logic [1:0] sel;
        logic [7:0] or2, r0, dm;
        logic [7:0] exp_pc;
        logic [2:0] exp_lvl;
        logic       exp_err;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic st, input logic rt, input logic cl, input logic lp,
                                input logic ip, input logic [1:0] sl, input logic [7:0] o,
                                input logic [7:0] r, input logic [7:0] d, input logic [7:0] p,
                                input logic [2:0] lv, input logic e);
        vec_t v;
        v.stall = st; v.ret = rt; v.call = cl; v.lpc = lp; v.ipc = ip; v.sel = sl;
        v.or2 = o; v.r0 = r; v.dm = d; v.exp_pc = p; v.exp_lvl = lv; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] lvl, input logic err);
        logic [ADDR_W-1:0] exp_pc;
        exp_pc = exp_q.pop_front();
        check({tag, ".pc"}, 32'(PC_out), 32'(exp_pc));
        check({tag, ".level"}, 32'(STK_LEVEL), 32'(lvl));
        check({tag, ".empty"}, 32'(STK_EMPTY), 32'(lvl == 3'd0));
        check({tag, ".full"}, 32'(STK_FULL), 32'(lvl == 3'(DEPTH)));
        check({tag, ".err"}, 32'(STK_ERR), 32'(err));
    endtask

    // driver
    task automatic drive(input logic st, input logic rt, input logic cl, input logic lp,
                         input logic ip, input logic [1:0] sl, input logic [7:0] o,
                         input logic [7:0] r, input logic [7:0] d);
        STALL = st; RET = rt; CALL = cl; L_PC = lp; I_PC = ip;
        {S11, S10} = sl; OR2_in = o; R0_in = r; DM_in = d;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // reference model state
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_stk[$];
    logic              m_err;

    function automatic logic [ADDR_W-1:0] m_target(input logic [1:0] sl, input logic [7:0] o,
                                                   input logic [7:0] r, input logic [7:0] d,
                                                   input logic [7:0] p);
        case (sl)
            2'd3:    return r;
            2'd2:    return d;
            2'd1:    return o;
            default: return 8'((int'(p) + int'($signed(o))) % 256);
        endcase
    endfunction

    initial begin
        vecs[0]  = mk(0,0,0,0,1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01, 3'd0, 0);
        vecs[1]  = mk(0,0,0,0,1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h02, 3'd0, 0);
        vecs[2]  = mk(0,0,0,0,1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h03, 3'd0, 0);
        vecs[3]  = mk(0,0,0,1,0, 2'd1, 8'h10, 8'h00, 8'h00, 8'h10, 3'd0, 0);
        vecs[4]  = mk(0,0,0,1,0, 2'd0, 8'hFC, 8'h00, 8'h00, 8'h0C, 3'd0, 0);
        vecs[5]  = mk(0,0,0,1,0, 2'd3, 8'h00, 8'h40, 8'h00, 8'h40, 3'd0, 0);
        vecs[6]  = mk(0,0,0,1,0, 2'd2, 8'h00, 8'h00, 8'hFF, 8'hFF, 3'd0, 0);
        vecs[7]  = mk(0,0,0,0,1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 0);
        vecs[8]  = mk(0,0,0,1,0, 2'd1, 8'h20, 8'h00, 8'h00, 8'h20, 3'd0, 0);
        vecs[9]  = mk(0,0,1,0,0, 2'd2, 8'h00, 8'h00, 8'h80, 8'h80, 3'd1, 0);
        vecs[10] = mk(0,1,0,0,0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h21, 3'd0, 0);
        vecs[11] = mk(1,0,1,1,1, 2'd3, 8'h00, 8'h77, 8'h00, 8'h21, 3'd0, 0);
        vecs[12] = mk(0,0,1,0,0, 2'd1, 8'h30, 8'h00, 8'h00, 8'h30, 3'd1, 0);
        vecs[13] = mk(0,0,1,0,0, 2'd3, 8'h00, 8'h50, 8'h00, 8'h50, 3'd2, 0);
        vecs[14] = mk(0,0,1,0,0, 2'd0, 8'h10, 8'h00, 8'h00, 8'h60, 3'd3, 0);
        vecs[15] = mk(0,0,1,0,0, 2'd2, 8'h00, 8'h00, 8'h70, 8'h70, 3'd4, 0);
        vecs[16] = mk(0,0,1,0,0, 2'd1, 8'h90, 8'h00, 8'h00, 8'h90, 3'd4, 1);
        vecs[17] = mk(0,1,1,0,0, 2'd3, 8'h00, 8'hAA, 8'h00, 8'h61, 3'd3, 1);
        vecs[18] = mk(0,1,0,0,0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h51, 3'd2, 1);
        vecs[19] = mk(0,1,0,0,0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h31, 3'd1, 1);
        vecs[20] = mk(0,1,0,0,0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h22, 3'd0, 1);
        vecs[21] = mk(0,1,0,0,0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h22, 3'd0, 1);
        vecs[22] = mk(0,0,0,1,1, 2'd3, 8'h00, 8'h05, 8'h00, 8'h05, 3'd0, 1);

        // reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        exp_q.push_back(8'h00);
        check_state("reset", 3'd0, 1'b0);
        RST = 1'b0;

        // directed vector table
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].stall, vecs[i].ret, vecs[i].call, vecs[i].lpc, vecs[i].ipc,
                  vecs[i].sel, vecs[i].or2, vecs[i].r0, vecs[i].dm);
            step();
            exp_q.push_back(vecs[i].exp_pc);
            check_state($sformatf("vec%0d", i), vecs[i].exp_lvl, vecs[i].exp_err);
        end

        // async reset between edges abandons a pending CALL
        drive(0,0,1,0,0, 2'd3, 8'h00, 8'h44, 8'h00);
        step();
        exp_q.push_back(8'h44);
        check_state("pre_rst_call", 3'd1, 1'b1);
        drive(0,0,1,0,0, 2'd2, 8'h00, 8'h00, 8'h99);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        check_state("async_rst", 3'd0, 1'b0);
        #1;
        RST = 1'b0;
        step();
        exp_q.push_back(8'h99);
        check_state("post_rst_call", 3'd1, 1'b0);

        // randomized traffic against the reference model
        RST = 1'b1;
        #2;
        RST = 1'b0;
        m_pc = 8'h00;
        m_stk.delete();
        m_err = 1'b0;
        for (int n = 0; n < 800; n++) begin
            logic st, rt, cl, lp, ip;
            logic [1:0] sl;
            logic [7:0] o, r, d;
            st = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 2) == 0);
            lp = ($urandom_range(0, 2) == 0);
            ip = ($urandom_range(0, 1) == 0);
            sl = 2'($urandom_range(0, 3));
            o  = 8'($urandom);
            r  = 8'($urandom);
            d  = 8'($urandom);
            drive(st, rt, cl, lp, ip, sl, o, r, d);
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b1;
                #2;
                RST = 1'b0;
                m_pc = 8'h00;
                m_stk.delete();
                m_err = 1'b0;
            end
            if (!st) begin
                if (rt) begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else m_err = 1'b1;
                end else if (cl) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(8'((int'(m_pc) + 1) % 256));
                    else m_err = 1'b1;
                    m_pc = m_target(sl, o, r, d, m_pc);
                end else if (lp) begin
                    m_pc = m_target(sl, o, r, d, m_pc);
                end else if (ip) begin
                    m_pc = 8'((int'(m_pc) + 1) % 256);
                end
            end
            step();
            exp_q.push_back(m_pc);
            check_state($sformatf("rnd%0d", n), 3'(m_stk.size()), m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of PC and all address inputs.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries, power of two, 2..16.
REQ-003 Parameter RESET_VEC, default 0: PC value after reset.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 STALL  input  1  freezes PC and stack for the cycle.
REQ-007 I_PC  input  1  increment request.
REQ-008 L_PC  input  1  load request, source chosen by S11,S10.
REQ-009 S11, S10  input  1 each  load source select: 11 R0_in, 10 DM_in, 01 OR2_in, 00 relative (PC + sign-extended OR2_in).
REQ-010 CALL  input  1  subroutine call: push return address, load target per S11,S10.
REQ-011 RET  input  1  return: pop stack top into PC.
REQ-012 OR2_in, R0_in, DM_in  input  ADDR_W each  load/target sources.
REQ-013 PC_out  output  ADDR_W  current PC, driven directly from a register.
REQ-014 STK_EMPTY  output  1  stack holds zero entries.
REQ-015 STK_FULL  output  1  stack holds STACK_DEPTH entries.
REQ-016 STK_LEVEL  output  clog2(STACK_DEPTH)+1  current entry count.
REQ-017 STK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-018 Per-cycle priority SHALL be: STALL > RET > CALL > L_PC > I_PC > hold.
REQ-019 STALL=1 SHALL hold PC, stack contents, STK_LEVEL and STK_ERR unchanged.
REQ-020 I_PC alone SHALL set PC <= PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
REQ-021 L_PC SHALL load the selected source; with select 00, target = PC + sign-extended OR2_in, modulo 2^ADDR_W.
REQ-022 Targets SHALL always be defined; no select value produces high-impedance or X.
REQ-023 CALL, not full: push PC+1 (mod 2^ADDR_W) to stack top, STK_LEVEL+1, PC <= target per S11,S10 (same rules as L_PC).
REQ-024 CALL, full: PC SHALL still load the target; push is discarded; STK_LEVEL unchanged; STK_ERR set to 1.
REQ-025 RET, not empty: PC <= stack top, STK_LEVEL-1, in one cycle.
REQ-026 RET, empty: PC held, STK_LEVEL stays 0, STK_ERR set to 1.
REQ-027 Asserting RET and CALL together SHALL execute RET only; CALL ignored that cycle.
REQ-028 Stack SHALL be LIFO; push and pop take effect the same cycle as the PC update; STK_EMPTY/STK_FULL/STK_LEVEL reflect the post-edge state combinationally from the level register.
REQ-029 STK_ERR SHALL remain 1 until reset; no other event clears it.
REQ-030 Outputs SHALL have zero-cycle latency from register state; every control action completes in exactly one clock.

Reset
REQ-031 RST=1 SHALL immediately, independent of CLK, force PC_out=RESET_VEC, STK_LEVEL=0, STK_EMPTY=1, STK_FULL=0, STK_ERR=0.
REQ-032 Stack entry contents SHALL be don't-care after reset; they are unreadable while empty.
REQ-033 Reset asserted mid-sequence (e.g., during CALL) SHALL abandon the operation; first edge after release obeys REQ-018.

Verification
REQ-034 Reset, then I_PC for 3 cycles with ADDR_W=8 -> PC_out 0x00,0x01,0x02,0x03; PC 0xFF + I_PC -> 0x00.
REQ-035 PC=0x10, L_PC, select 00, OR2_in=0xFC -> PC=0x0C; select 11, R0_in=0x40 -> PC=0x40.
REQ-036 PC=0x20, CALL select 10, DM_in=0x80 -> PC=0x80, STK_LEVEL=1; then RET -> PC=0x21, STK_EMPTY=1.
REQ-037 Five nested CALLs at STACK_DEPTH=4 -> fifth loads target, STK_FULL=1, STK_ERR=1; four RETs return in reverse order; fifth RET holds PC.
REQ-038 STALL with I_PC, L_PC, CALL all high -> PC and STK_LEVEL unchanged; RST pulse between edges -> PC_out=RESET_VEC before next edge, STK_ERR=0.
